// File: rtl/gf_chisq_pkg.sv
// Shared types and helpers for the multi-lane chi-square accumulator.
// No ports: it provides the track-state enum, clog2, the accumulator width,
// the saturation fill value and the lane-slice index helper.
package gf_chisq_pkg;

    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_OPEN = 1'b1
    } trk_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Holds MAXTERMS full-scale squares without wrapping.
    function automatic int acc_width(input int pw, input int cntw);
        return 2 * pw + cntw;
    endfunction

    function automatic logic [63:0] sat_ones(input int bits);
        return (bits >= 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/dsp_chisq_accum_multi_if.sv
// Bus bundle of the chi-square accumulator: residual input with framing
// and result output. master drives the inputs; slave is the accumulator.
interface dsp_chisq_accum_multi_if #(
    parameter int NCHAN          = 4,
    parameter int PARAMETERWIDTH = 15,
    parameter int CHISQBITS      = 32,
    parameter int CNTW           = 5
);
    logic [NCHAN*PARAMETERWIDTH-1:0] CHI_IN;
    logic                            VALID_IN;
    logic                            FIRST_IN;
    logic                            LAST_IN;
    logic [NCHAN*CHISQBITS-1:0]      CHISQ_OUT;
    logic                            VALID_OUT;
    logic [NCHAN-1:0]                OVERFLOW_OUT;
    logic [CNTW-1:0]                 NTERMS_OUT;
    logic                            FRAME_ERR_OUT;

    modport master (
        output CHI_IN, VALID_IN, FIRST_IN, LAST_IN,
        input  CHISQ_OUT, VALID_OUT, OVERFLOW_OUT,
        input  NTERMS_OUT, FRAME_ERR_OUT
    );

    modport slave (
        input  CHI_IN, VALID_IN, FIRST_IN, LAST_IN,
        output CHISQ_OUT, VALID_OUT, OVERFLOW_OUT,
        output NTERMS_OUT, FRAME_ERR_OUT
    );
endinterface

// File: rtl/chisq_lane.sv
// One lane: S1 data register, S2 square, S3 accumulator, sticky overflow and
// scaled/saturated output. Ports: clk, rst_n, chi (raw residual), strobes
// load/add/mark_full/emit from the parent, chisq and ovf result registers.
module chisq_lane
    import gf_chisq_pkg::*;
#(
    parameter int PW        = 15,
    parameter int CHISQBITS = 32,
    parameter int SHIFT     = 15,
    parameter int ACCW      = 35
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PW-1:0]        chi,
    input  logic                 load,
    input  logic                 add,
    input  logic                 mark_full,
    input  logic                 emit,
    output logic [CHISQBITS-1:0] chisq,
    output logic                 ovf
);
    localparam int SQW = 2 * PW - 1;
    localparam int RW  = ACCW - SHIFT;
    // At least one bit above CHISQBITS so the range test is always legal.
    localparam int EW  = (RW > CHISQBITS) ? RW : CHISQBITS + 1;
    localparam logic [CHISQBITS-1:0] SAT = CHISQBITS'(sat_ones(CHISQBITS));

    logic [PW-1:0]   chi_s1;
    logic [2*PW-1:0] ext;
    logic [SQW-1:0]  sq;
    logic [SQW-1:0]  sq_s2;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_next;
    logic            sticky;
    logic            sticky_next;
    logic [EW-1:0]   raw;
    logic            too_big;
    logic            sat;

    // Low 2*PW-1 product bits are exact, including (-2^(PW-1))^2.
    assign ext = {{PW{chi_s1[PW-1]}}, chi_s1};
    assign sq  = SQW'(ext * ext);

    always_comb begin
        acc_next    = acc;
        sticky_next = sticky;
        unique case (1'b1)
            load: begin
                acc_next    = ACCW'(sq_s2);
                sticky_next = 1'b0;
            end
            add:       acc_next    = acc + ACCW'(sq_s2);
            mark_full: sticky_next = 1'b1;
            default: ;
        endcase
    end

    assign raw     = EW'(acc_next >> SHIFT);
    assign too_big = (raw >> CHISQBITS) != '0;
    assign sat     = too_big | sticky_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chi_s1 <= '0;
            sq_s2  <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            chisq  <= '0;
            ovf    <= 1'b0;
        end else begin
            chi_s1 <= chi;
            sq_s2  <= sq;
            acc    <= acc_next;
            sticky <= sticky_next;
            if (emit) begin
                chisq <= sat ? SAT : raw[CHISQBITS-1:0];
                ovf   <= sat;
            end
        end
    end
endmodule

// File: rtl/dsp_chisq_accum_multi.sv
// Multi-lane chi-square accumulator over FIRST/LAST framed tracks.
// Ports: CLK_IN, RESET_N (async, active low), bus (slave: CHI_IN, VALID_IN,
// FIRST_IN, LAST_IN in; CHISQ_OUT, VALID_OUT, OVERFLOW_OUT, NTERMS_OUT,
// FRAME_ERR_OUT out). Top owns control pipe, track FSM, counter, framing.
module dsp_chisq_accum_multi
    import gf_chisq_pkg::*;
#(
    parameter int NCHAN          = 4,
    parameter int PARAMETERWIDTH = 15,
    parameter int CHISQBITS      = 32,
    parameter int SHIFT          = 15,
    parameter int MAXTERMS       = 16
) (
    input logic CLK_IN,
    input logic RESET_N,
    dsp_chisq_accum_multi_if.slave bus
);
    localparam int PW   = PARAMETERWIDTH;
    localparam int CNTW = clog2(MAXTERMS + 1);
    localparam int ACCW = acc_width(PW, CNTW);
    localparam logic [CNTW-1:0] MAXCNT = CNTW'(MAXTERMS);

    logic v1, f1, l1;
    logic v2, f2, l2;
    trk_state_t state, state_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic open, start, cont, full;
    logic load, add, mark_full, emit, ferr;
    logic [CHISQBITS-1:0] chisq [NCHAN];
    logic                 ovf   [NCHAN];

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            {v1, f1, l1} <= '0;
            {v2, f2, l2} <= '0;
        end else begin
            v1 <= bus.VALID_IN;
            f1 <= bus.VALID_IN & bus.FIRST_IN;
            l1 <= bus.VALID_IN & bus.LAST_IN;
            {v2, f2, l2} <= {v1, f1, l1};
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) state <= TRK_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (v2 && f2)
            state_next = l2 ? TRK_IDLE : TRK_OPEN;
        else if (v2 && l2 && state == TRK_OPEN)
            state_next = TRK_IDLE;
    end

    // FIRST always restarts; a non-FIRST term only counts inside a track.
    always_comb begin
        open      = (state == TRK_OPEN);
        start     = v2 & f2;
        cont      = v2 & ~f2 & open;
        full      = (cnt == MAXCNT);
        load      = start;
        add       = cont & ~full;
        mark_full = cont & full;
        emit      = v2 & l2 & (f2 | open);
        ferr      = v2 & (f2 ? open : ~open);
        cnt_next  = cnt;
        if (load)     cnt_next = CNTW'(1);
        else if (add) cnt_next = cnt + CNTW'(1);
    end

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt               <= '0;
            bus.VALID_OUT     <= 1'b0;
            bus.FRAME_ERR_OUT <= 1'b0;
            bus.NTERMS_OUT    <= '0;
        end else begin
            cnt               <= cnt_next;
            bus.VALID_OUT     <= emit;
            bus.FRAME_ERR_OUT <= ferr;
            if (emit) bus.NTERMS_OUT <= cnt_next;
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_lane
        chisq_lane #(
            .PW        (PW),
            .CHISQBITS (CHISQBITS),
            .SHIFT     (SHIFT),
            .ACCW      (ACCW)
        ) u_lane (
            .clk       (CLK_IN),
            .rst_n     (RESET_N),
            .chi       (bus.CHI_IN[lane_lo(g, PW) +: PW]),
            .load      (load),
            .add       (add),
            .mark_full (mark_full),
            .emit      (emit),
            .chisq     (chisq[g]),
            .ovf       (ovf[g])
        );
    end

    always_comb begin
        bus.CHISQ_OUT    = '0;
        bus.OVERFLOW_OUT = '0;
        for (int i = 0; i < NCHAN; i++) begin
            bus.CHISQ_OUT[lane_lo(i, CHISQBITS) +: CHISQBITS] = chisq[i];
            bus.OVERFLOW_OUT[i] = ovf[i];
        end
    end
endmodule

// File: tb/tb_dsp_chisq_accum_multi.sv
// Bench for dsp_chisq_accum_multi: 32-bit and 8-bit output instances share
// stimulus; a track model fills a scoreboard popped on VALID_OUT.
module tb_dsp_chisq_accum_multi;
    localparam int NCH  = 4;
    localparam int PW   = 15;
    localparam int CNTW = 5;
    localparam int MAXT = 16;
    localparam longint LIM32 = 64'd4294967296;
    localparam longint LIM8  = 64'd256;

    typedef struct {
        logic [NCH*32-1:0] c32;
        logic [NCH*8-1:0]  c8;
        logic [NCH-1:0]    o32;
        logic [NCH-1:0]    o8;
        logic [CNTW-1:0]   n;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH*PW-1:0] chi = '0;
    logic valid = 1'b0;
    logic first = 1'b0;
    logic last  = 1'b0;

    always #5 clk = ~clk;

    dsp_chisq_accum_multi_if #(
        .NCHAN(NCH), .PARAMETERWIDTH(PW), .CHISQBITS(32), .CNTW(CNTW)
    ) bw ();
    dsp_chisq_accum_multi_if #(
        .NCHAN(NCH), .PARAMETERWIDTH(PW), .CHISQBITS(8), .CNTW(CNTW)
    ) bn ();

    assign bw.CHI_IN   = chi;
    assign bw.VALID_IN = valid;
    assign bw.FIRST_IN = first;
    assign bw.LAST_IN  = last;
    assign bn.CHI_IN   = chi;
    assign bn.VALID_IN = valid;
    assign bn.FIRST_IN = first;
    assign bn.LAST_IN  = last;

    dsp_chisq_accum_multi #(
        .NCHAN(NCH), .PARAMETERWIDTH(PW), .CHISQBITS(32),
        .SHIFT(15), .MAXTERMS(MAXT)
    ) u_wide (
        .CLK_IN(clk), .RESET_N(rst_n), .bus(bw)
    );

    dsp_chisq_accum_multi #(
        .NCHAN(NCH), .PARAMETERWIDTH(PW), .CHISQBITS(8),
        .SHIFT(15), .MAXTERMS(MAXT)
    ) u_narrow (
        .CLK_IN(clk), .RESET_N(rst_n), .bus(bn)
    );

    int checks   = 0;
    int errors   = 0;
    int n_valid  = 0;
    int n_valid8 = 0;
    int n_ferr   = 0;
    int exp_ferr = 0;
    int n_push   = 0;
    exp_t sb[$];
    exp_t mon_e;

    bit     m_open   = 1'b0;
    int     m_cnt    = 0;
    bit     m_sticky = 1'b0;
    longint m_acc[NCH];

    always @(negedge clk) begin
        if (bw.FRAME_ERR_OUT) n_ferr++;
        if (bn.VALID_OUT) n_valid8++;
        if (bw.VALID_OUT) begin
            n_valid++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: VALID_OUT=1, required no result");
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (bw.CHISQ_OUT !== mon_e.c32) begin
                    errors++;
                    $display("FAIL sb_chisq32: got %h required %h", bw.CHISQ_OUT, mon_e.c32);
                end
                checks++;
                if (bw.OVERFLOW_OUT !== mon_e.o32) begin
                    errors++;
                    $display("FAIL sb_ovf32: got %b required %b", bw.OVERFLOW_OUT, mon_e.o32);
                end
                checks++;
                if (bw.NTERMS_OUT !== mon_e.n) begin
                    errors++;
                    $display("FAIL sb_nterms: got %0d required %0d", bw.NTERMS_OUT, mon_e.n);
                end
                checks++;
                if (bn.VALID_OUT !== 1'b1 || bn.CHISQ_OUT !== mon_e.c8) begin
                    errors++;
                    $display("FAIL sb_chisq8: got v=%b %h required v=1 %h",
                             bn.VALID_OUT, bn.CHISQ_OUT, mon_e.c8);
                end
                checks++;
                if (bn.OVERFLOW_OUT !== mon_e.o8) begin
                    errors++;
                    $display("FAIL sb_ovf8: got %b required %b", bn.OVERFLOW_OUT, mon_e.o8);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic push_result();
        exp_t e;
        longint raw;
        for (int i = 0; i < NCH; i++) begin
            raw = m_acc[i] >>> 15;
            e.o32[i] = m_sticky || (raw >= LIM32);
            e.o8[i]  = m_sticky || (raw >= LIM8);
            e.c32[i*32 +: 32] = e.o32[i] ? 32'hFFFF_FFFF : raw[31:0];
            e.c8[i*8 +: 8]    = e.o8[i]  ? 8'hFF : raw[7:0];
        end
        e.n = CNTW'(m_cnt);
        sb.push_back(e);
        n_push++;
    endtask

    task automatic set_term(input int d0, input int d1, input int d2,
                            input int d3, input bit f, input bit l);
        int d[NCH];
        logic [31:0] w;
        longint v;
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < NCH; i++) begin
            w = d[i];
            chi[i*PW +: PW] = w[PW-1:0];
        end
        valid = 1'b1;
        first = f;
        last  = l;
        if (f) begin
            if (m_open) exp_ferr++;
            m_open   = 1'b1;
            m_cnt    = 1;
            m_sticky = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                w = d[i];
                v = longint'($signed(w[PW-1:0]));
                m_acc[i] = v * v;
            end
        end else if (!m_open) begin
            exp_ferr++;
        end else if (m_cnt >= MAXT) begin
            m_sticky = 1'b1;
        end else begin
            m_cnt++;
            for (int i = 0; i < NCH; i++) begin
                w = d[i];
                v = longint'($signed(w[PW-1:0]));
                m_acc[i] += v * v;
            end
        end
        if (l && m_open) begin
            push_result();
            m_open = 1'b0;
        end
    endtask

    task automatic term(input int d0, input int d1, input int d2,
                        input int d3, input bit f, input bit l);
        set_term(d0, d1, d2, d3, f, l);
        @(negedge clk);
        valid = 1'b0;
        first = 1'b0;
        last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    task automatic check_zero(input string tag);
        checks++;
        if (bw.VALID_OUT !== 1'b0 || bw.FRAME_ERR_OUT !== 1'b0 ||
            bw.CHISQ_OUT !== '0 || bw.OVERFLOW_OUT !== '0 ||
            bw.NTERMS_OUT !== '0) begin
            errors++;
            $display("FAIL %s_wide: got v=%b fe=%b c=%h o=%b n=%0d required all 0",
                     tag, bw.VALID_OUT, bw.FRAME_ERR_OUT, bw.CHISQ_OUT,
                     bw.OVERFLOW_OUT, bw.NTERMS_OUT);
        end
        checks++;
        if (bn.VALID_OUT !== 1'b0 || bn.CHISQ_OUT !== '0 ||
            bn.OVERFLOW_OUT !== '0) begin
            errors++;
            $display("FAIL %s_narrow: got v=%b c=%h o=%b required all 0",
                     tag, bn.VALID_OUT, bn.CHISQ_OUT, bn.OVERFLOW_OUT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        int cyc;
        int v0;
        v0 = n_valid;
        set_term(16384, 181, 0, 0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        first = 1'b0;
        last  = 1'b0;
        cyc = 1;
        while (bw.VALID_OUT !== 1'b1 && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL single_latency: got %0d edges required 3", cyc);
        end
        idle(3);
        checks++;
        if (bw.CHISQ_OUT[31:0] !== 32'd8192 || bw.NTERMS_OUT !== 5'd1 ||
            bw.OVERFLOW_OUT !== 4'b0000) begin
            errors++;
            $display("FAIL single_value: got c=%0d n=%0d o=%b required 8192 1 0000",
                     bw.CHISQ_OUT[31:0], bw.NTERMS_OUT, bw.OVERFLOW_OUT);
        end
        checks++;
        if (bn.CHISQ_OUT[15:0] !== 16'h00FF || bn.OVERFLOW_OUT !== 4'b0001) begin
            errors++;
            $display("FAIL single_sat8: got c=%h o=%b required 00ff 0001",
                     bn.CHISQ_OUT[15:0], bn.OVERFLOW_OUT);
        end
        checks++;
        if (n_valid - v0 !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d results required 1", n_valid - v0);
        end
    endtask

    task automatic test_gap();
        term(16384, 1, -3, 0, 1'b1, 1'b0);
        idle(2);
        term(-16384, 1, 5, 0, 1'b0, 1'b0);
        idle(2);
        term(0, 1, 7, 0, 1'b0, 1'b1);
        idle(5);
        checks++;
        if (bw.CHISQ_OUT[31:0] !== 32'd16384 || bw.CHISQ_OUT[63:32] !== 32'd0 ||
            bw.NTERMS_OUT !== 5'd3) begin
            errors++;
            $display("FAIL gap_value: got l0=%0d l1=%0d n=%0d required 16384 0 3",
                     bw.CHISQ_OUT[31:0], bw.CHISQ_OUT[63:32], bw.NTERMS_OUT);
        end
    endtask

    task automatic test_limit();
        logic [NCH*32-1:0] ones;
        ones = '1;
        for (int i = 0; i < 18; i++)
            term(-16384, -16384, -16384, -16384, i == 0, i == 17);
        idle(5);
        checks++;
        if (bw.NTERMS_OUT !== 5'd16 || bw.OVERFLOW_OUT !== 4'hF ||
            bw.CHISQ_OUT !== ones) begin
            errors++;
            $display("FAIL limit: got n=%0d o=%b c=%h required 16 1111 all ones",
                     bw.NTERMS_OUT, bw.OVERFLOW_OUT, bw.CHISQ_OUT);
        end
    endtask

    task automatic test_abort();
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        term(100, 0, 0, 0, 1'b1, 1'b0);
        term(200, 0, 0, 0, 1'b0, 1'b0);
        term(16384, 2, 0, 0, 1'b1, 1'b0);
        term(16384, 2, 0, 0, 1'b0, 1'b1);
        idle(5);
        checks++;
        if (n_valid - v0 !== 1 || n_ferr - f0 !== 1) begin
            errors++;
            $display("FAIL abort_counts: got %0d results %0d errs required 1 1",
                     n_valid - v0, n_ferr - f0);
        end
        checks++;
        if (bw.CHISQ_OUT[31:0] !== 32'd16384 || bw.NTERMS_OUT !== 5'd2) begin
            errors++;
            $display("FAIL abort_value: got c=%0d n=%0d required 16384 2",
                     bw.CHISQ_OUT[31:0], bw.NTERMS_OUT);
        end
    endtask

    task automatic test_orphan();
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        term(5, 5, 5, 5, 1'b0, 1'b1);
        idle(5);
        checks++;
        if (n_valid - v0 !== 0 || n_ferr - f0 !== 1) begin
            errors++;
            $display("FAIL orphan: got %0d results %0d err cycles required 0 1",
                     n_valid - v0, n_ferr - f0);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        int len;
        v0 = n_valid;
        term(16384, 0, 0, 0, 1'b1, 1'b1);
        term(-16384, 100, 0, 0, 1'b1, 1'b0);
        term(16384, 100, 0, 0, 1'b0, 1'b1);
        idle(5);
        checks++;
        if (n_valid - v0 !== 2 || bw.CHISQ_OUT[31:0] !== 32'd16384 ||
            bw.NTERMS_OUT !== 5'd2) begin
            errors++;
            $display("FAIL b2b: got %0d results c=%0d n=%0d required 2 16384 2",
                     n_valid - v0, bw.CHISQ_OUT[31:0], bw.NTERMS_OUT);
        end
        for (int t = 0; t < 20; t++) begin
            len = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++)
                term(rnd(), rnd(), rnd(), rnd(), k == 0, k == len - 1);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(5);
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = n_valid;
        term(1000, 1000, 1000, 1000, 1'b1, 1'b0);
        term(2000, 2000, 2000, 2000, 1'b0, 1'b0);
        rst_n = 1'b0;
        m_open = 1'b0;
        m_cnt  = 0;
        @(negedge clk);
        check_zero("reset_mid");
        rst_n = 1'b1;
        term(3000, 3000, 3000, 3000, 1'b0, 1'b1);
        idle(5);
        checks++;
        if (n_valid - v0 !== 0) begin
            errors++;
            $display("FAIL reset_mid_drop: got %0d results required 0", n_valid - v0);
        end
        term(16384, 0, 0, 0, 1'b1, 1'b0);
        term(16384, 0, 0, 0, 1'b0, 1'b1);
        idle(5);
        checks++;
        if (n_valid - v0 !== 1 || bw.CHISQ_OUT[31:0] !== 32'd16384) begin
            errors++;
            $display("FAIL reset_mid_next: got %0d results c=%0d required 1 16384",
                     n_valid - v0, bw.CHISQ_OUT[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_limit();
        test_abort();
        test_orphan();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0 || n_valid !== n_push || n_valid8 !== n_push) begin
            errors++;
            $display("FAIL drain: got left=%0d wide=%0d narrow=%0d required 0 %0d %0d",
                     sb.size(), n_valid, n_valid8, n_push, n_push);
        end
        checks++;
        if (n_ferr !== exp_ferr) begin
            errors++;
            $display("FAIL frame_err_total: got %0d required %0d", n_ferr, exp_ferr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
